// File: rtl/note_judge_pkg.sv
// note_pkg: lane count, judge states and default timing/points shared with the note sender
package note_pkg;
  localparam int LANES = 5;
  localparam int DEF_WINDOW_CYCLES = 5000000;
  localparam int DEF_HIT_POINTS = 10;
  typedef enum logic [1:0] {IDLE, ARMED, JUDGED} judge_state_t;
endpackage

// File: rtl/note_judge_edge.sv
// lane_edge_detect: registered per-lane rising edge (CMP=0) or nonzero-change event on bit 0 (CMP=1)
module lane_edge_detect #(
  parameter int W = 5,
  parameter bit CMP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] evt
);
  logic [W-1:0] prev;
  always_ff @(posedge clk) prev <= rst ? '0 : d;
  always_comb evt = CMP ? W'((d != prev) && (|d)) : d & ~prev;
endmodule

// File: rtl/note_judge.sv
// note_judge: judges each expected note HIT/MISS within a timed window; NOTE_JUDGE_COMBO_MULT_EN adds a combo score multiplier
module note_judge #(
  parameter int LANES = note_pkg::LANES,
  parameter int WINDOW_CYCLES = note_pkg::DEF_WINDOW_CYCLES,
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 8,
  parameter int HIT_POINTS = note_pkg::DEF_HIT_POINTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES-1:0]   exp_notes,
  input  logic [LANES-1:0]   buttons,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic               window_open
);
  import note_pkg::*;
  localparam int CW = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;
  judge_state_t state, state_n;
  logic [LANES-1:0] target, target_n, acc, acc_n, press, note_evt;
  logic [CW-1:0] cnt, cnt_n;
  logic new_note, judge_hit, judge_miss;
  logic [SCORE_W-1:0] points;
  logic [SCORE_W:0] sum;
  lane_edge_detect #(.W(LANES), .CMP(1'b1)) u_note (.clk(clk), .rst(reset), .d(exp_notes), .evt(note_evt));
  lane_edge_detect #(.W(LANES), .CMP(1'b0)) u_btn (.clk(clk), .rst(reset), .d(buttons), .evt(press));
  assign new_note = |note_evt;
`ifdef NOTE_JUDGE_COMBO_MULT_EN
  logic [COMBO_W-1:0] tier;
  logic [2:0] mult;
  always_comb begin
    tier = combo >> 3;
    mult = (tier >= COMBO_W'(3)) ? 3'd4 : 3'(tier) + 3'd1;
    points = SCORE_W'(HIT_POINTS * int'(mult));
  end
`else
  assign points = SCORE_W'(HIT_POINTS);
`endif
  assign sum = {1'b0, score} + {1'b0, points};
  // a press arriving with a new note is judged against that note in the same cycle
  always_comb begin
    state_n = state;
    target_n = target;
    acc_n = acc;
    cnt_n = cnt;
    judge_hit = 1'b0;
    judge_miss = 1'b0;
    if (state == ARMED) begin
      if (new_note) begin
        judge_miss = 1'b1;
        target_n = exp_notes;
        acc_n = press;
        cnt_n = CW'(WINDOW_CYCLES - 1);
      end else if (|(press & ~target)) begin
        judge_miss = 1'b1;
        state_n = JUDGED;
      end else if ((acc | press) == target) begin
        judge_hit = 1'b1;
        state_n = JUDGED;
      end else if (cnt == '0) begin
        judge_miss = 1'b1;
        state_n = JUDGED;
      end else begin
        acc_n = acc | press;
        cnt_n = cnt - 1'b1;
      end
    end else if (new_note) begin
      target_n = exp_notes;
      acc_n = press;
      cnt_n = CW'(WINDOW_CYCLES - 1);
      judge_miss = |(press & ~exp_notes);
      judge_hit = !judge_miss && (press == exp_notes);
      state_n = (judge_miss || judge_hit) ? JUDGED : ARMED;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      target <= '0;
      acc <= '0;
      cnt <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      score <= '0;
      combo <= '0;
      window_open <= 1'b0;
    end else begin
      state <= state_n;
      target <= target_n;
      acc <= acc_n;
      cnt <= cnt_n;
      hit <= judge_hit;
      miss <= judge_miss;
      window_open <= (state_n == ARMED);
      if (judge_hit) begin
        score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        combo <= (&combo) ? combo : combo + 1'b1;
      end else if (judge_miss) begin
        combo <= '0;
      end
    end
  end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed stimulus with a judgement scoreboard for note_judge
module tb_note_judge;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] exp_notes = '0, buttons = '0;
  logic hit, miss, window_open, hit6, miss6, wo6;
  logic [15:0] score;
  logic [7:0] combo, combo6;
  logic [5:0] score6;
  int checks = 0, errors = 0;
  int m_score = 0, m_combo = 0, m_score6 = 0;
  typedef struct {logic h; logic [15:0] s; logic [7:0] c; logic [5:0] s6;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  note_judge #(.WINDOW_CYCLES(8), .HIT_POINTS(10)) dut (
    .clk(clk), .reset(reset), .exp_notes(exp_notes), .buttons(buttons),
    .hit(hit), .miss(miss), .score(score), .combo(combo), .window_open(window_open));
  note_judge #(.WINDOW_CYCLES(8), .HIT_POINTS(10), .SCORE_W(6)) dut6 (
    .clk(clk), .reset(reset), .exp_notes(exp_notes), .buttons(buttons),
    .hit(hit6), .miss(miss6), .score(score6), .combo(combo6), .window_open(wo6));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_hit();
    int pts;
    pts = 10;
`ifdef NOTE_JUDGE_COMBO_MULT_EN
    pts = 10 * (1 + (((m_combo >> 3) > 3) ? 3 : (m_combo >> 3)));
`endif
    m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
    m_score6 = (m_score6 + pts > 63) ? 63 : m_score6 + pts;
    m_combo = (m_combo == 255) ? 255 : m_combo + 1;
    q.push_back('{1'b1, 16'(m_score), 8'(m_combo), 6'(m_score6)});
  endtask

  task automatic expect_miss();
    m_combo = 0;
    q.push_back('{1'b0, 16'(m_score), 8'(m_combo), 6'(m_score6)});
  endtask

  always @(negedge clk) begin
    if (hit || miss || hit6 || miss6) begin
      chk("hit_miss_exclusive", {31'd0, hit && miss}, 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, hit, miss}, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_hit", {31'd0, hit}, {31'd0, e.h});
        chk("pulse_miss", {31'd0, miss}, {31'd0, !e.h});
        chk("pulse6_match", {30'd0, hit6, miss6}, {30'd0, hit, miss});
        chk("sb_score", {16'd0, score}, {16'd0, e.s});
        chk("sb_combo", {24'd0, combo}, {24'd0, e.c});
        chk("sb_combo6", {24'd0, combo6}, {24'd0, e.c});
        chk("sb_score6", {26'd0, score6}, {26'd0, e.s6});
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_hit", {31'd0, hit}, 0);
    chk("rst_miss", {31'd0, miss}, 0);
    chk("rst_score", {16'd0, score}, 0);
    chk("rst_combo", {24'd0, combo}, 0);
    chk("rst_window", {31'd0, window_open}, 0);
    reset = 1'b0;
    tick(1);
    // clean hit: lanes 0 and 2 pressed on separate cycles
    exp_notes = 5'b00101;
    tick(1);
    chk("clean_window_open", {31'd0, window_open}, 1);
    tick(1);
    buttons = 5'b00001;
    tick(1);
    chk("clean_partial_nohit", {31'd0, hit}, 0);
    chk("clean_partial_window", {31'd0, window_open}, 1);
    tick(1);
    expect_hit();
    buttons = 5'b00101;
    tick(1);
    chk("clean_hit", {31'd0, hit}, 1);
    chk("clean_window_falls", {31'd0, window_open}, 0);
    chk("clean_score", {16'd0, score}, 10);
    tick(1);
    chk("clean_hit_one_cycle", {31'd0, hit}, 0);
    buttons = '0;
    // timeout after exactly 8 armed cycles
    exp_notes = 5'b01010;
    tick(1);
    buttons = 5'b00010;
    tick(6);
    chk("timeout_early", {31'd0, miss}, 0);
    expect_miss();
    tick(1);
    chk("timeout_last_cycle", {31'd0, miss}, 0);
    chk("timeout_still_open", {31'd0, window_open}, 1);
    tick(1);
    chk("timeout_miss", {31'd0, miss}, 1);
    chk("timeout_combo", {24'd0, combo}, 0);
    chk("timeout_score", {16'd0, score}, 10);
    buttons = '0;
    tick(1);
    // wrong lane, then correct presses are ignored
    exp_notes = 5'b10100;
    tick(1);
    expect_miss();
    buttons = 5'b00001;
    tick(1);
    chk("wrong_miss", {31'd0, miss}, 1);
    chk("wrong_window", {31'd0, window_open}, 0);
    buttons = 5'b10101;
    tick(3);
    chk("wrong_no_pulse", {30'd0, hit, miss}, 0);
    buttons = '0;
    tick(1);
    // overlap: new note while armed
    exp_notes = 5'b11000;
    tick(3);
    expect_miss();
    exp_notes = 5'b10100;
    tick(1);
    chk("overlap_miss", {31'd0, miss}, 1);
    chk("overlap_rearmed", {31'd0, window_open}, 1);
    expect_hit();
    buttons = 5'b10100;
    tick(1);
    chk("overlap_hit", {31'd0, hit}, 1);
    buttons = '0;
    tick(1);
    // saturation on the 6-bit score instance
    for (int i = 0; i < 7; i++) begin
      exp_notes = i[0] ? 5'b00001 : 5'b00010;
      tick(1);
      expect_hit();
      buttons = exp_notes;
      tick(1);
      buttons = '0;
      tick(1);
    end
    chk("sat_score6", {26'd0, score6}, 63);
    chk("sat_score16", {16'd0, score}, 90);
    chk("sat_combo", {24'd0, combo}, 8);
    // reset mid-window discards the note
    exp_notes = 5'b01000;
    tick(1);
    chk("rst_mid_window_open", {31'd0, window_open}, 1);
    reset = 1'b1;
    exp_notes = '0;
    tick(1);
    chk("rst_mid_pulses", {30'd0, hit, miss}, 0);
    chk("rst_mid_score", {16'd0, score}, 0);
    chk("rst_mid_score6", {26'd0, score6}, 0);
    chk("rst_mid_combo", {24'd0, combo}, 0);
    chk("rst_mid_window", {30'd0, window_open, wo6}, 0);
    reset = 1'b0;
    m_score = 0;
    m_combo = 0;
    m_score6 = 0;
    tick(2);
    // nine consecutive single-cycle hits
    for (int i = 0; i < 9; i++) begin
      exp_notes = i[0] ? 5'b11000 : 5'b00011;
      buttons = exp_notes;
      expect_hit();
      tick(1);
      chk("single_cycle_hit", {31'd0, hit}, 1);
      buttons = '0;
      tick(1);
    end
`ifdef NOTE_JUDGE_COMBO_MULT_EN
    chk("streak_score", {16'd0, score}, 100);
`else
    chk("streak_score", {16'd0, score}, 90);
`endif
    chk("streak_combo", {24'd0, combo}, 9);
    tick(2);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
